// File: rtl/alu_issue.sv
// Instruction sequencer in front of the combinational ALU: buffers ops in a FIFO,
// issues one at a time, captures the result and returns it over valid/ready.
module alu_issue #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_op,
   input  logic [7:0]  in_a,
   input  logic [7:0]  in_b,
   output logic [3:0]  alu_cmd,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   input  logic [15:0] alu_res,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [15:0] res_data,
   output logic        res_err,
   output logic [7:0]  err_count
);

   localparam int unsigned AW = $clog2(DEPTH);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;

   logic [1:0]  state;
   logic [19:0] mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        full;
   logic        empty;
   logic        push;
   logic        load;
   logic        legal;
   logic [19:0] head;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);

   assign in_ready  = !full;
   assign push      = in_valid && in_ready;
   assign load      = !empty && ((state == IDLE) || ((state == HOLD) && res_ready));
   assign head      = mem[rd_ptr[AW-1:0]];
   assign legal     = (alu_cmd <= 4'h4);
   assign res_valid = (state == HOLD);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {in_op, in_a, in_b};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         alu_cmd   <= 4'hF;
         alu_a     <= 8'h00;
         alu_b     <= 8'h00;
         res_data  <= 16'h0000;
         res_err   <= 1'b0;
         err_count <= 8'h00;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (load) begin
            rd_ptr  <= rd_ptr + 1'b1;
            alu_cmd <= head[19:16];
            alu_a   <= head[15:8];
            alu_b   <= head[7:0];
         end
         case (state)
            IDLE: begin
               if (!empty) begin
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               state <= HOLD;
               // Illegal opcodes leave the ALU output floating, so it is never sampled.
               if (legal) begin
                  res_data <= alu_res;
                  res_err  <= 1'b0;
               end else begin
                  res_data <= 16'h0000;
                  res_err  <= 1'b1;
                  if (err_count != 8'hFF) begin
                     err_count <= err_count + 8'h01;
                  end
               end
            end
            HOLD: begin
               if (res_ready) begin
                  state <= empty ? IDLE : ISSUE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: a behavioural ALU drives alu_res, expected results are
// queued at acceptance and checked by an independent monitor at each result handshake.
module tb_alu_issue;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic [3:0]  alu_cmd;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [15:0] alu_res;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_data;
   logic        res_err;
   logic [7:0]  err_count;

   typedef struct {
      logic [15:0] data;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   time  hs_t[$];
   int   checks = 0;
   int   failures = 0;
   int   model_err = 0;
   int   ready_mode = 1;  // 0 = low, 1 = high, 2 = random

   alu_issue #(.DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .alu_cmd   (alu_cmd),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_res   (alu_res),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_err   (res_err),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] ref_res(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
      int ia = int'(a);
      int ib = int'(b);
      int r;
      case (op)
         4'h0:    r = ia + ib;
         4'h1:    r = (ia - ib) & 'hFFFF;
         4'h2:    r = 'hFFFF - ia;
         4'h3:    r = ia & ib;
         4'h4:    r = ia | ib;
         default: r = 0;
      endcase
      return r[15:0];
   endfunction

   // Behavioural ALU; a recognisable junk value stands in for the floating output.
   always_comb begin
      alu_res = (alu_cmd <= 4'h4) ? ref_res(alu_cmd, alu_a, alu_b) : 16'hDEAD;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // res_ready is driven late in the cycle so the negedge monitor sees a settled value.
   initial begin
      res_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       res_ready = 1'b0;
            1:       res_ready = 1'b1;
            default: res_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin : monitor
      logic        hold_prev;
      logic [15:0] prev_data;
      logic        prev_err;
      exp_t        e;
      hold_prev = 1'b0;
      prev_data = '0;
      prev_err  = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold_prev = 1'b0;
         end else begin
            if (hold_prev && res_valid) begin
               chk("stable_data", 32'(res_data), 32'(prev_data));
               chk("stable_err", 32'(res_err), 32'(prev_err));
            end
            hold_prev = res_valid && !res_ready;
            prev_data = res_data;
            prev_err  = res_err;
            if (res_valid && res_ready) begin
               hs_t.push_back($time);
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL spurious_result actual=%h required=none at %0t", res_data,
                           $time);
               end else begin
                  e = exp_q.pop_front();
                  chk("res_data", 32'(res_data), 32'(e.data));
                  chk("res_err", 32'(res_err), 32'(e.err));
                  if (e.err && model_err < 255) model_err++;
                  chk("err_count", 32'(err_count), 32'(model_err));
               end
            end
         end
      end
   end

   task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      logic rdy;
      exp_t e;
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      for (int i = 0; i < 500; i++) begin
         rdy = in_ready;
         @(posedge clk);
         if (rdy) begin
            e.data = (op <= 4'h4) ? ref_res(op, a, b) : 16'h0000;
            e.err  = (op > 4'h4);
            exp_q.push_back(e);
            #1;
            in_valid = 1'b0;
            return;
         end
      end
      chk("push_timeout", 32'd1, 32'd0);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         if (exp_q.size() == 0 && !res_valid) begin
            #1;
            return;
         end
      end
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_alu_cmd"}, 32'(alu_cmd), 32'hF);
      chk({tag, "_alu_a"}, 32'(alu_a), 32'd0);
      chk({tag, "_alu_b"}, 32'(alu_b), 32'd0);
      chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
      chk({tag, "_res_data"}, 32'(res_data), 32'd0);
      chk({tag, "_res_err"}, 32'(res_err), 32'd0);
      chk({tag, "_err_count"}, 32'(err_count), 32'd0);
   endtask

   initial begin : stim
      logic [3:0] op;
      in_valid = 1'b0;
      in_op    = 4'h0;
      in_a     = 8'h00;
      in_b     = 8'h00;
      rst_n    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Latency of a single ADD with carry into bit 8
      push(4'h0, 8'hFF, 8'h01);
      @(negedge clk);
      chk("lat_n_valid", 32'(res_valid), 32'd0);
      @(negedge clk);
      chk("lat_n1_cmd", 32'(alu_cmd), 32'h0);
      chk("lat_n1_a", 32'(alu_a), 32'hFF);
      chk("lat_n1_b", 32'(alu_b), 32'h01);
      chk("lat_n1_valid", 32'(res_valid), 32'd0);
      @(negedge clk);
      chk("lat_n2_valid", 32'(res_valid), 32'd1);
      chk("lat_n2_data", 32'(res_data), 32'h0100);
      drain();

      // Back-to-back with res_ready high: results two cycles apart
      hs_t.delete();
      push(4'h1, 8'h03, 8'h05);
      push(4'h2, 8'h0F, 8'h00);
      push(4'h3, 8'hF0, 8'h3C);
      push(4'h4, 8'hF0, 8'h0F);
      drain();
      chk("b2b_count", 32'(hs_t.size()), 32'd4);
      if (hs_t.size() == 4) begin
         for (int i = 1; i < 4; i++) chk("b2b_gap", 32'(hs_t[i] - hs_t[i-1]), 32'd20);
      end
      chk("held_cmd", 32'(alu_cmd), 32'h4);
      chk("held_a", 32'(alu_a), 32'hF0);

      // Illegal opcode followed by a legal one
      push(4'h9, 8'h12, 8'h34);
      push(4'h0, 8'h01, 8'h01);
      drain();
      chk("err_count_one", 32'(err_count), 32'd1);

      // Back-pressure: 5 accepted (4 buffered + 1 held), then the 6th waits
      ready_mode = 0;
      for (int i = 0; i < 5; i++) push(4'(i % 5), 8'(8'h10 + i), 8'(8'h20 + i));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_res_valid", 32'(res_valid), 32'd1);
      end
      @(posedge clk);
      #1;
      ready_mode = 1;
      push(4'h1, 8'h00, 8'h01);
      drain();

      // Randomised traffic with random consumer back-pressure
      ready_mode = 2;
      for (int i = 0; i < 150; i++) begin
         op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
         push(op, 8'($urandom), 8'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
         end
      end
      drain();

      // Saturation of the illegal-op counter
      ready_mode = 1;
      for (int i = 0; i < 256; i++) push(4'($urandom_range(5, 15)), 8'($urandom), 8'($urandom));
      drain();
      chk("err_sat", 32'(err_count), 32'hFF);
      push(4'hF, 8'h00, 8'h00);
      drain();
      chk("err_sat_hold", 32'(err_count), 32'hFF);

      // Asynchronous reset while in ISSUE with three instructions still queued
      ready_mode = 0;
      for (int i = 0; i < 5; i++) push(4'h0, 8'(i), 8'h01);
      @(posedge clk);
      #1;
      ready_mode = 1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      model_err = 0;
      #1;
      check_reset_vals("midrst");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("no_stale", 32'(res_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      push(4'h0, 8'h01, 8'h01);
      drain();
      chk("post_rst_cmd", 32'(alu_cmd), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
